sync_debounce: RTL and testbench
================================

# sync_debounce

Parametrised multi-channel input conditioner: each of WIDTH asynchronous inputs passes through a STAGES-deep synchroniser, then a per-channel debounce filter, onto the destination clock. It also emits single-cycle rise and fall pulses. It is the next-generation front end for buttons, switches and slow external status lines feeding the wave-generator control logic. It replaces single-bit two-flop hardening with one block for a whole input bus.

## Interface
- WIDTH, 1: number of independent channels.
- STAGES, 2: synchroniser depth; legal values are 2 or more.
- DEBOUNCE_CYCLES, 16: number of consecutive cycles a new synchronised level must persist before it is accepted; legal values are 1 or more.
- RESET_VAL, {WIDTH{1'b0}}: reset level of every synchroniser stage and of signal_dst.

- clk_dst  input  1  destination clock; one clock domain only.
- rst_dst  input  1  asynchronous reset, active-high.
- signal_src  input  WIDTH  asynchronous inputs, one per channel.
- signal_dst  output  WIDTH  synchronised, debounced level; registered.
- rise_pulse  output  WIDTH  one-cycle high when signal_dst[i] goes 0→1; registered.
- fall_pulse  output  WIDTH  one-cycle high when signal_dst[i] goes 1→0; registered.
- any_change  output  1  OR of rise_pulse and fall_pulse across all channels; registered.

## Operation
- Reset (asynchronous, while rst_dst is high):
  - all synchroniser stages = RESET_VAL; signal_dst = RESET_VAL.
  - all counters = 0.
  - rise_pulse, fall_pulse and any_change = 0.
  - Assertion mid-count aborts any pending change. After release, no pulse is generated for the reset value.
- Synchroniser, per channel:
  - shift chain sync[0..STAGES-1]; sync[0] samples signal_src[i].
  - s = sync[STAGES-1].
  - No logic is placed between stages.
- Debounce, per channel: a two-state machine, implicit in the counter.
  - IDLE, when cnt == 0 and s == signal_dst[i]: hold.
  - If s != signal_dst[i]:
    - cnt < DEBOUNCE_CYCLES-1: cnt <= cnt+1.
    - cnt == DEBOUNCE_CYCLES-1: signal_dst[i] <= s, cnt <= 0, and assert the matching pulse.
  - If s == signal_dst[i] while counting: cnt <= 0. A glitch shorter than DEBOUNCE_CYCLES is fully rejected, and the count restarts from zero on the next mismatch.
- Counter width is $clog2(DEBOUNCE_CYCLES+1). The counter never wraps, because it is cleared at its terminal value.
- Pulses:
  - rise_pulse[i] and fall_pulse[i] are registered on the same edge that updates signal_dst[i], and deassert on the next edge unless a new acceptance occurs.
  - They are never high simultaneously for one channel.
- Channels are fully independent. Simultaneous acceptances on several channels each pulse in the same cycle, and any_change is a single-cycle high.

## Timing
- Let edge 1 be the first rising edge that samples a new, stable input level.
  - s changes after edge STAGES.
  - signal_dst and the pulse change at edge STAGES+DEBOUNCE_CYCLES.
- Minimum accepted input pulse width is DEBOUNCE_CYCLES clock periods of stable level at s.
- Register-to-output only; no combinational path from any input to any output.
- Place a tight max-delay constraint between sync[0] and sync[1]. sync[0] is the metastable stage.

## Configuration
- SYNC_DEBOUNCE_FILTER_EN defined: debounce counters are present, with the behaviour described above.
- SYNC_DEBOUNCE_FILTER_EN undefined:
  - counters are removed and DEBOUNCE_CYCLES is ignored.
  - signal_dst[i] <= s every cycle, so signal_dst changes at edge STAGES+1.
  - Pulses are generated from the signal_dst update exactly as above, so every synchronised transition pulses.

## Structure
- Shared package sync_pkg:
  - clog2 helper.
  - default constants SYNC_STAGES_DEF = 2 and DEBOUNCE_CYCLES_DEF = 16.
- Sub-module sync_debounce_chan: one channel containing the chain, counter and pulse registers.
  - Top level generates WIDTH instances and the any_change OR register.

## Test plan
- Reset release: hold rst_dst high, drive signal_src = all ones, release. Required: signal_dst = 0 and no pulses until edge STAGES+DEBOUNCE_CYCLES. Then rise_pulse = all ones for exactly 1 cycle and any_change = 1 for 1 cycle.
- Latency: WIDTH=4, STAGES=3, DEBOUNCE_CYCLES=5; step signal_src[2] 0→1. Required: signal_dst[2] rises at edge 8, with rise_pulse[2] high for cycle 8 only.
- Glitch reject: DEBOUNCE_CYCLES=5; drive a 4-cycle high glitch on channel 0. Required: signal_dst[0] stays 0 and there are no pulses. A following 5-cycle high is accepted.
- Simultaneous: channel 0 rises and channel 1 falls on the same edge. Required: rise_pulse[0] and fall_pulse[1] in the same cycle, and any_change high for exactly 1 cycle.
- Reset mid-count: assert rst_dst when cnt = 3 of 5. Required: outputs go to RESET_VAL immediately, asynchronously, and no pulse appears after release while the input equals RESET_VAL.
- Macro off: build without SYNC_DEBOUNCE_FILTER_EN, STAGES=2. Required: a 1-cycle input pulse held through sampling appears on signal_dst at edge 3 and produces both a rise and a fall pulse.

Source files
------------

// File: rtl/sync_pkg.sv
// sync_pkg: constants and helpers shared by the sync_debounce block.
//   SYNC_STAGES_DEF     default synchroniser depth
//   DEBOUNCE_CYCLES_DEF default debounce acceptance length
//   clog2()             ceiling log2, usable in parameter expressions
package sync_pkg;

  localparam int SYNC_STAGES_DEF     = 2;
  localparam int DEBOUNCE_CYCLES_DEF = 16;

  // Returns the smallest n with 2**n >= value (0 for value <= 1).
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/sync_debounce_chan.sv
// sync_debounce_chan: one channel of the input conditioner.
// Synchroniser chain, optional debounce counter, and registered edge pulses.
//
// Build option: SYNC_DEBOUNCE_FILTER_EN
//   defined   -> a new synchronised level must persist DEBOUNCE_CYCLES cycles
//   undefined -> signal_dst follows the synchroniser output every cycle
//
// Ports:
//   clk_dst      destination clock
//   rst_dst      asynchronous reset, active-high
//   signal_src   asynchronous input bit
//   signal_dst   synchronised, debounced level (registered)
//   rise_pulse   one-cycle pulse on signal_dst 0->1 (registered)
//   fall_pulse   one-cycle pulse on signal_dst 1->0 (registered)
//   change_next  combinational "a pulse registers on the next edge" strobe,
//                used by the top to register any_change in step with the pulses
//
// Debounce behaviour (implicit in the counter):
//   state | meaning
//   IDLE  | cnt == 0 and synchronised level equals signal_dst
//   COUNT | synchronised level differs; cnt counts edges of persistence
module sync_debounce_chan
  import sync_pkg::*;
#(
  parameter int   STAGES          = SYNC_STAGES_DEF,
  parameter int   DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter logic RESET_VAL       = 1'b0
) (
  input  logic clk_dst,
  input  logic rst_dst,
  input  logic signal_src,
  output logic signal_dst,
  output logic rise_pulse,
  output logic fall_pulse,
  output logic change_next
);

  if (STAGES < 2 || DEBOUNCE_CYCLES < 1) begin : g_bad_cfg
    $error("sync_debounce_chan: need STAGES >= 2 and DEBOUNCE_CYCLES >= 1");
  end

  // sync[0] is the metastable stage; the sync[0] -> sync[1] hop carries a
  // tight max-delay constraint, so nothing may sit between the stages.
  logic [STAGES-1:0] sync;
  logic              s;
  logic              dst_next;
  logic              rise_next;
  logic              fall_next;

  assign s = sync[STAGES-1];

  always_ff @(posedge clk_dst or posedge rst_dst) begin
    if (rst_dst) begin
      sync <= {STAGES{RESET_VAL}};
    end else begin
      sync <= {sync[STAGES-2:0], signal_src};
    end
  end

`ifdef SYNC_DEBOUNCE_FILTER_EN
  localparam int               CNT_W    = clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;

  always_ff @(posedge clk_dst or posedge rst_dst) begin
    if (rst_dst) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_next;
    end
  end

  // Any agreement clears the count, so a glitch is forgotten entirely.
  // The count is cleared at its terminal value and therefore never wraps.
  always_comb begin
    cnt_next = '0;
    dst_next = signal_dst;
    if (s != signal_dst) begin
      if (cnt == CNT_TERM) begin
        dst_next = s;
      end else begin
        cnt_next = cnt + CNT_W'(1);
      end
    end
  end
`else
  assign dst_next = s;
`endif

  assign rise_next   = ~signal_dst &  dst_next;
  assign fall_next   =  signal_dst & ~dst_next;
  assign change_next = rise_next | fall_next;

  always_ff @(posedge clk_dst or posedge rst_dst) begin
    if (rst_dst) begin
      signal_dst <= RESET_VAL;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      signal_dst <= dst_next;
      rise_pulse <= rise_next;
      fall_pulse <= fall_next;
    end
  end

endmodule

// File: rtl/sync_debounce.sv
// sync_debounce: multi-channel input conditioner onto clk_dst.
// Each of WIDTH asynchronous inputs is synchronised (STAGES flops), debounced
// and edge-detected; any_change flags a pulse on any channel.
//
// Build option: SYNC_DEBOUNCE_FILTER_EN enables the debounce counters; when
// undefined, signal_dst follows the synchroniser and DEBOUNCE_CYCLES is unused.
//
// Ports:
//   clk_dst     destination clock
//   rst_dst     asynchronous reset, active-high
//   signal_src  [WIDTH] asynchronous inputs
//   signal_dst  [WIDTH] synchronised, debounced levels (registered)
//   rise_pulse  [WIDTH] one-cycle pulse per channel on 0->1 (registered)
//   fall_pulse  [WIDTH] one-cycle pulse per channel on 1->0 (registered)
//   any_change  OR of all rise/fall pulses, aligned with them (registered)
module sync_debounce
  import sync_pkg::*;
#(
  parameter int               WIDTH           = 1,
  parameter int               STAGES          = SYNC_STAGES_DEF,
  parameter int               DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter logic [WIDTH-1:0] RESET_VAL       = {WIDTH{1'b0}}
) (
  input  logic             clk_dst,
  input  logic             rst_dst,
  input  logic [WIDTH-1:0] signal_src,
  output logic [WIDTH-1:0] signal_dst,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse,
  output logic             any_change
);

  logic [WIDTH-1:0] change_next;

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    sync_debounce_chan #(
      .STAGES          (STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .RESET_VAL       (RESET_VAL[i])
    ) u_chan (
      .clk_dst     (clk_dst),
      .rst_dst     (rst_dst),
      .signal_src  (signal_src[i]),
      .signal_dst  (signal_dst[i]),
      .rise_pulse  (rise_pulse[i]),
      .fall_pulse  (fall_pulse[i]),
      .change_next (change_next[i])
    );
  end

  // Registered from the channels' next-cycle strobes so any_change rises on
  // the same edge as the pulses rather than one cycle behind them.
  always_ff @(posedge clk_dst or posedge rst_dst) begin
    if (rst_dst) begin
      any_change <= 1'b0;
    end else begin
      any_change <= |change_next;
    end
  end

endmodule

// File: tb/tb_sync_debounce.sv
module tb_sync_debounce;

  localparam int W  = 4;
  localparam int ST = 3;
  localparam int DB = 5;
  localparam logic [W-1:0] RV = '0;
`ifdef SYNC_DEBOUNCE_FILTER_EN
  localparam bit FILTER = 1'b1;
`else
  localparam bit FILTER = 1'b0;
`endif
  // Edge (counted from the first sampling edge) at which a new level lands.
  localparam int EXP_LAT = FILTER ? ST + DB : ST + 1;

  logic         clk;
  logic         rst;
  logic [W-1:0] src;
  logic [W-1:0] signal_dst;
  logic [W-1:0] rise_pulse;
  logic [W-1:0] fall_pulse;
  logic         any_change;

  int n_cmp = 0;
  int n_bad = 0;

  sync_debounce #(
    .WIDTH           (W),
    .STAGES          (ST),
    .DEBOUNCE_CYCLES (DB),
    .RESET_VAL       (RV)
  ) dut (
    .clk_dst    (clk),
    .rst_dst    (rst),
    .signal_src (src),
    .signal_dst (signal_dst),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse),
    .any_change (any_change)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: inputs seen at s are the samples from ST edges ago; a
  // level is accepted once it has disagreed with the output on DB
  // consecutive edges (or on the first edge when the filter is absent).
  logic [W-1:0] m_hist [ST];
  logic [W-1:0] m_dst;
  int           m_run  [W];
  logic [W-1:0] exp_rise, exp_fall;
  logic         exp_any;

  task automatic model_reset();
    for (int k = 0; k < ST; k++) m_hist[k] = RV;
    for (int c = 0; c < W; c++) m_run[c] = 0;
    m_dst = RV; exp_rise = '0; exp_fall = '0; exp_any = 1'b0;
  endtask

  task automatic model_edge(input logic [W-1:0] din);
    logic [W-1:0] s;
    s = m_hist[ST-1];
    exp_rise = '0; exp_fall = '0;
    for (int c = 0; c < W; c++) begin
      if (s[c] != m_dst[c]) begin
        m_run[c] = m_run[c] + 1;
        if (!FILTER || m_run[c] >= DB) begin
          exp_rise[c] = s[c];
          exp_fall[c] = ~s[c];
          m_dst[c]    = s[c];
          m_run[c]    = 0;
        end
      end else begin
        m_run[c] = 0;
      end
    end
    exp_any = |(exp_rise | exp_fall);
    for (int k = ST - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
    m_hist[0] = din;
  endtask

  // Called away from the edge; applies v, advances one edge, updates model.
  task automatic step(input logic [W-1:0] v);
    src = v;
    @(posedge clk);
    model_edge(v);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    int hit;
    hit = -1;
    rst = 1'b1; src = '1;
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    n_cmp++;
    if ({signal_dst, rise_pulse, fall_pulse, any_change} !== {m_dst, exp_rise, exp_fall, exp_any}) begin
      n_bad++;
      $display("FAIL reset_hold got dst=%b r=%b f=%b a=%b need all zero", signal_dst, rise_pulse, fall_pulse, any_change);
    end
    rst = 1'b0;
    for (int c = 1; c <= EXP_LAT + 4; c++) begin
      step('1);
      n_cmp++;
      if ({signal_dst, rise_pulse, fall_pulse, any_change} !== {m_dst, exp_rise, exp_fall, exp_any}) begin
        n_bad++;
        $display("FAIL reset_release edge=%0d got dst=%b r=%b f=%b a=%b need dst=%b r=%b f=%b a=%b",
                 c, signal_dst, rise_pulse, fall_pulse, any_change, m_dst, exp_rise, exp_fall, exp_any);
      end
      if (rise_pulse === '1 && hit < 0) hit = c;
    end
    n_cmp++;
    if (hit !== EXP_LAT) begin
      n_bad++;
      $display("FAIL reset_rise_edge got %0d need %0d", hit, EXP_LAT);
    end
  endtask

  task automatic test_latency();
    int hit;
    hit = -1;
    do_reset();
    repeat (3) step('0);
    for (int c = 1; c <= EXP_LAT + 5; c++) begin
      step(4'b0100);
      n_cmp++;
      if ({signal_dst, rise_pulse, fall_pulse, any_change} !== {m_dst, exp_rise, exp_fall, exp_any}) begin
        n_bad++;
        $display("FAIL latency edge=%0d got dst=%b r=%b f=%b a=%b need dst=%b r=%b f=%b a=%b",
                 c, signal_dst, rise_pulse, fall_pulse, any_change, m_dst, exp_rise, exp_fall, exp_any);
      end
      if (signal_dst[2] === 1'b1 && hit < 0) hit = c;
    end
    n_cmp++;
    if (hit !== EXP_LAT) begin
      n_bad++;
      $display("FAIL latency_edge got %0d need %0d", hit, EXP_LAT);
    end
  endtask

  task automatic test_glitch();
    int nr, nf;
    do_reset();
    nr = 0;
    for (int c = 0; c < 4 + 12; c++) begin
      step(c < 4 ? 4'b0001 : 4'b0000);
      n_cmp++;
      if ({signal_dst, rise_pulse, fall_pulse, any_change} !== {m_dst, exp_rise, exp_fall, exp_any}) begin
        n_bad++;
        $display("FAIL glitch cyc=%0d got dst=%b r=%b f=%b a=%b need dst=%b r=%b f=%b a=%b",
                 c, signal_dst, rise_pulse, fall_pulse, any_change, m_dst, exp_rise, exp_fall, exp_any);
      end
      if (rise_pulse[0] === 1'b1) nr++;
    end
    n_cmp++;
    if (nr !== (FILTER ? 0 : 1)) begin
      n_bad++;
      $display("FAIL glitch_rises got %0d need %0d", nr, FILTER ? 0 : 1);
    end
    nr = 0; nf = 0;
    for (int c = 0; c < 5 + 14; c++) begin
      step(c < 5 ? 4'b0001 : 4'b0000);
      n_cmp++;
      if ({signal_dst, rise_pulse, fall_pulse, any_change} !== {m_dst, exp_rise, exp_fall, exp_any}) begin
        n_bad++;
        $display("FAIL accept5 cyc=%0d got dst=%b r=%b f=%b a=%b need dst=%b r=%b f=%b a=%b",
                 c, signal_dst, rise_pulse, fall_pulse, any_change, m_dst, exp_rise, exp_fall, exp_any);
      end
      if (rise_pulse[0] === 1'b1) nr++;
      if (fall_pulse[0] === 1'b1) nf++;
    end
    n_cmp++;
    if (nr !== 1 || nf !== 1) begin
      n_bad++;
      $display("FAIL accept5_pulses got rise=%0d fall=%0d need 1 and 1", nr, nf);
    end
  endtask

  task automatic test_short_pulse();
    int nr, nf;
    nr = 0; nf = 0;
    do_reset();
    for (int c = 0; c < 14; c++) begin
      step(c == 0 ? 4'b0001 : 4'b0000);
      n_cmp++;
      if ({signal_dst, rise_pulse, fall_pulse, any_change} !== {m_dst, exp_rise, exp_fall, exp_any}) begin
        n_bad++;
        $display("FAIL short_pulse cyc=%0d got dst=%b r=%b f=%b a=%b need dst=%b r=%b f=%b a=%b",
                 c, signal_dst, rise_pulse, fall_pulse, any_change, m_dst, exp_rise, exp_fall, exp_any);
      end
      if (rise_pulse[0] === 1'b1) nr++;
      if (fall_pulse[0] === 1'b1) nf++;
    end
    n_cmp++;
    if (nr !== (FILTER ? 0 : 1) || nf !== (FILTER ? 0 : 1)) begin
      n_bad++;
      $display("FAIL short_pulse_count got rise=%0d fall=%0d need %0d each", nr, nf, FILTER ? 0 : 1);
    end
  endtask

  task automatic test_simultaneous();
    int r0, f1, na;
    r0 = -1; f1 = -1; na = 0;
    do_reset();
    repeat (EXP_LAT + 3) step(4'b0010);
    for (int c = 0; c < EXP_LAT + 5; c++) begin
      step(4'b0001);
      n_cmp++;
      if ({signal_dst, rise_pulse, fall_pulse, any_change} !== {m_dst, exp_rise, exp_fall, exp_any}) begin
        n_bad++;
        $display("FAIL simultaneous cyc=%0d got dst=%b r=%b f=%b a=%b need dst=%b r=%b f=%b a=%b",
                 c, signal_dst, rise_pulse, fall_pulse, any_change, m_dst, exp_rise, exp_fall, exp_any);
      end
      if (rise_pulse[0] === 1'b1 && r0 < 0) r0 = c;
      if (fall_pulse[1] === 1'b1 && f1 < 0) f1 = c;
      if (any_change === 1'b1) na++;
    end
    n_cmp++;
    if (r0 < 0 || r0 !== f1 || na !== 1) begin
      n_bad++;
      $display("FAIL simultaneous_align got rise0=%0d fall1=%0d any_cycles=%0d need equal and 1", r0, f1, na);
    end
  endtask

  task automatic test_reset_mid();
    int np;
    np = 0;
    do_reset();
    repeat (EXP_LAT + 3) step('1);
    repeat (ST + 3) step('0);
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({signal_dst, rise_pulse, fall_pulse, any_change} !== {RV, 4'b0000, 4'b0000, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_mid_async got dst=%b r=%b f=%b a=%b need dst=%b and no pulses",
               signal_dst, rise_pulse, fall_pulse, any_change, RV);
    end
    @(posedge clk);
    #1;
    model_reset();
    rst = 1'b0;
    for (int c = 0; c < EXP_LAT + 6; c++) begin
      step('0);
      n_cmp++;
      if ({signal_dst, rise_pulse, fall_pulse, any_change} !== {m_dst, exp_rise, exp_fall, exp_any}) begin
        n_bad++;
        $display("FAIL reset_mid_after cyc=%0d got dst=%b r=%b f=%b a=%b need dst=%b r=%b f=%b a=%b",
                 c, signal_dst, rise_pulse, fall_pulse, any_change, m_dst, exp_rise, exp_fall, exp_any);
      end
      if (any_change === 1'b1 || rise_pulse !== '0 || fall_pulse !== '0) np++;
    end
    n_cmp++;
    if (np !== 0) begin
      n_bad++;
      $display("FAIL reset_mid_pulses got %0d pulse cycles need 0", np);
    end
  endtask

  task automatic test_random();
    int           hold [W];
    logic [W-1:0] v;
    v = '0;
    for (int c = 0; c < W; c++) hold[c] = 0;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      for (int c = 0; c < W; c++) begin
        if (hold[c] == 0) begin
          v[c]    = 1'($urandom_range(0, 1));
          hold[c] = int'($urandom_range(1, DB + 3));
        end
        hold[c]--;
      end
      step(v);
      n_cmp++;
      if ({signal_dst, rise_pulse, fall_pulse, any_change} !== {m_dst, exp_rise, exp_fall, exp_any}) begin
        n_bad++;
        $display("FAIL random cyc=%0d in=%b got dst=%b r=%b f=%b a=%b need dst=%b r=%b f=%b a=%b",
                 n, v, signal_dst, rise_pulse, fall_pulse, any_change, m_dst, exp_rise, exp_fall, exp_any);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    src = '0;
    model_reset();
    test_reset();
    test_latency();
    test_glitch();
    test_short_pulse();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
